// File: rtl/w_pattern_serializer.sv
// Pattern serializer feeding the sequence detector: captures a parallel pattern
// and replays it on w, one bit held for DIV clocks, single-shot or repeating.
module w_pattern_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DIV       = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [WIDTH-1:0]         pattern,
    input  logic                     repeat_en,
    input  logic                     halt,
    output logic                     w,
    output logic                     bit_strobe,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned IdxW = $clog2(WIDTH);
    // One spare bit so DIV-1 never aliases with a wrapped count.
    localparam int unsigned DivW = $clog2(DIV) + 1;

    localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  shreg_q;
    logic [WIDTH-1:0]  saved_q;
    logic [DivW-1:0]   div_q;
    logic [WIDTH-1:0]  shreg_next;

    // Bit that goes on w first for a given register image.
    function automatic logic first_bit(input logic [WIDTH-1:0] p);
        return LSB_FIRST ? p[0] : p[WIDTH-1];
    endfunction

    // Move the next bit in transmit order into the first_bit position.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] p);
        return LSB_FIRST ? (p >> 1) : (p << 1);
    endfunction

    assign shreg_next = advance(shreg_q);

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            saved_q    <= '0;
            div_q      <= '0;
            w          <= 1'b0;
            bit_strobe <= 1'b0;
            bit_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            bit_strobe <= 1'b0;
            done       <= 1'b0;
            case (state_q)
                StIdle: begin
                    w    <= 1'b0;
                    busy <= 1'b0;
                    // halt wins over a simultaneous load
                    if (load && !halt) begin
                        state_q    <= StShift;
                        shreg_q    <= pattern;
                        saved_q    <= pattern;
                        div_q      <= '0;
                        bit_idx    <= '0;
                        w          <= first_bit(pattern);
                        bit_strobe <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                StShift: begin
                    if (halt) begin
                        state_q <= StIdle;
                        w       <= 1'b0;
                        busy    <= 1'b0;
                    end else if (div_q == DivLast) begin
                        div_q <= '0;
                        if (bit_idx != IdxLast) begin
                            shreg_q    <= shreg_next;
                            bit_idx    <= bit_idx + IdxW'(1);
                            w          <= first_bit(shreg_next);
                            bit_strobe <= 1'b1;
                        end else if (repeat_en) begin
                            // Back-to-back replay: no gap cycle, no done pulse.
                            shreg_q    <= saved_q;
                            bit_idx    <= '0;
                            w          <= first_bit(saved_q);
                            bit_strobe <= 1'b1;
                        end else begin
                            state_q <= StDone;
                            w       <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        div_q <= div_q + DivW'(1);
                    end
                end
                StDone: begin
                    // Load is ignored here; halt leads to the same place.
                    state_q <= StIdle;
                    w       <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    w       <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_w_pattern_serializer.sv
// Scoreboard bench for w_pattern_serializer: two instances (DIV=4 LSB-first and
// DIV=1 MSB-first) share stimulus; a position-based model predicts each output cycle.
module tb_w_pattern_serializer;

    typedef struct packed {
        int         cyc;
        logic       w;
        logic       strobe;
        logic       done;
        logic [2:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic       repeat_en = 1'b0;
    logic       halt = 1'b0;

    logic [1:0] w_v;
    logic [1:0] bs_v;
    logic [1:0] busy_v;
    logic [1:0] done_v;
    logic [2:0] idx_a;
    logic [2:0] idx_b;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic fin = 1'b0;

    exp_t q0[$];
    exp_t q1[$];

    // Model state per instance: position within the current pass of the pattern.
    logic       active [2];
    logic       indone [2];
    int         pos [2];
    logic [7:0] pat [2];
    int         dv;
    int         k;
    exp_t       e_m;
    exp_t       e0;
    logic       have;

    w_pattern_serializer #(.WIDTH(8), .DIV(4), .LSB_FIRST(1'b1)) u_a (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .pattern    (pattern),
        .repeat_en  (repeat_en),
        .halt       (halt),
        .w          (w_v[0]),
        .bit_strobe (bs_v[0]),
        .bit_idx    (idx_a),
        .busy       (busy_v[0]),
        .done       (done_v[0])
    );

    w_pattern_serializer #(.WIDTH(8), .DIV(1), .LSB_FIRST(1'b0)) u_b (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .pattern    (pattern),
        .repeat_en  (repeat_en),
        .halt       (halt),
        .w          (w_v[1]),
        .bit_strobe (bs_v[1]),
        .bit_idx    (idx_b),
        .busy       (busy_v[1]),
        .done       (done_v[1])
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d: got %0h expected %0h", name, d, cyc, act, exp);
        end
    endtask

    task automatic score(input int d, input logic hv, input exp_t e, input logic w_a,
                         input logic bs_a, input logic busy_a, input logic done_a,
                         input logic [2:0] idx_x);
        if (busy_a || done_a) begin
            chk("output_expected", d, 32'(hv), 32'd1);
            if (hv) begin
                chk("w", d, 32'(w_a), 32'(e.w));
                chk("done", d, 32'(done_a), 32'(e.done));
                chk("busy", d, 32'(busy_a), 32'(!e.done));
                if (!e.done) begin
                    chk("bit_strobe", d, 32'(bs_a), 32'(e.strobe));
                    chk("bit_idx", d, 32'(idx_x), 32'(e.idx));
                end
            end
        end else begin
            chk("no_missing_output", d, 32'(hv), 32'd0);
            chk("idle_w", d, 32'(w_a), 32'd0);
            chk("idle_strobe", d, 32'(bs_a), 32'd0);
            if (!reset) chk("reset_idx", d, 32'(idx_x), 32'd0);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: per edge, decide what each instance shows in the next cycle.
    initial begin
        for (int d = 0; d < 2; d++) begin
            active[d] = 1'b0;
            indone[d] = 1'b0;
            pos[d]    = 0;
            pat[d]    = 8'h00;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                dv = (d == 0) ? 4 : 1;
                if (!reset || halt) begin
                    active[d] = 1'b0;
                    indone[d] = 1'b0;
                end else if (indone[d]) begin
                    indone[d] = 1'b0;
                end else if (active[d]) begin
                    pos[d] = pos[d] + 1;
                    if (pos[d] == 8 * dv) begin
                        if (repeat_en) begin
                            pos[d] = 0;
                        end else begin
                            active[d] = 1'b0;
                            indone[d] = 1'b1;
                        end
                    end
                end else if (load) begin
                    active[d] = 1'b1;
                    pos[d]    = 0;
                    pat[d]    = pattern;
                end
                if (active[d] || indone[d]) begin
                    k          = pos[d] / dv;
                    e_m.cyc    = cyc + 1;
                    e_m.done   = indone[d];
                    e_m.w      = active[d] ? ((d == 0) ? pat[d][k] : pat[d][7-k]) : 1'b0;
                    e_m.strobe = active[d] && (pos[d] % dv == 0);
                    e_m.idx    = 3'(k);
                    if (d == 0) q0.push_back(e_m);
                    else q1.push_back(e_m);
                end
            end
            cyc = cyc + 1;
        end
    end

    // Monitor: on each falling edge, match DUT outputs against the queued expectations.
    initial begin
        forever begin
            @(negedge clk);
            while (q0.size() > 0 && q0[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale_expect dut0 cyc=%0d: got none expected cyc %0d", cyc,
                         q0[0].cyc);
                void'(q0.pop_front());
            end
            have = (q0.size() > 0) && (q0[0].cyc == cyc);
            if (have) e0 = q0.pop_front();
            else e0 = '0;
            score(0, have, e0, w_v[0], bs_v[0], busy_v[0], done_v[0], idx_a);

            while (q1.size() > 0 && q1[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale_expect dut1 cyc=%0d: got none expected cyc %0d", cyc,
                         q1[0].cyc);
                void'(q1.pop_front());
            end
            have = (q1.size() > 0) && (q1[0].cyc == cyc);
            if (have) e0 = q1.pop_front();
            else e0 = '0;
            score(1, have, e0, w_v[1], bs_v[1], busy_v[1], done_v[1], idx_b);

            if (fin) begin
                chk("queue_drained", 0, 32'(q0.size()), 32'd0);
                chk("queue_drained", 1, 32'(q1.size()), 32'd0);
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized mix.
    initial begin
        #1;
        reset   = 1'b0;
        load    = 1'b1;
        pattern = 8'hFF;
        tick(3);
        reset = 1'b1;
        tick(1);
        load = 1'b0;
        tick(40);

        // single shot, LSB-first bits 0,1,0,0,1,1,0,1 on instance a
        pattern = 8'b1011_0010;
        load    = 1'b1;
        tick(1);
        load = 1'b0;
        tick(40);

        pattern = 8'hA5;
        load    = 1'b1;
        tick(1);
        load = 1'b0;
        tick(40);

        // random single shots, some loads landing in DONE
        repeat (6) begin
            pattern = 8'($urandom);
            load    = 1'b1;
            tick(1);
            load = 1'b0;
            tick(34 + int'($urandom_range(3, 0)));
        end

        // repeat mode with an ignored reload mid-stream
        repeat_en = 1'b1;
        pattern   = 8'h0F;
        load      = 1'b1;
        tick(1);
        load = 1'b0;
        tick(10);
        pattern = 8'hF0;
        load    = 1'b1;
        tick(1);
        load = 1'b0;
        tick(60);
        repeat_en = 1'b0;
        tick(40);

        // halt while instance a shows bit 3
        pattern = 8'($urandom);
        load    = 1'b1;
        tick(1);
        load = 1'b0;
        tick(13);
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        tick(3);
        pattern = 8'($urandom);
        load    = 1'b1;
        tick(1);
        load = 1'b0;
        tick(40);

        // reset asserted mid-bit
        pattern = 8'($urandom);
        load    = 1'b1;
        tick(1);
        load = 1'b0;
        tick(9);
        #2 reset = 1'b0;
        tick(2);
        reset   = 1'b1;
        pattern = 8'($urandom);
        load    = 1'b1;
        tick(1);
        load = 1'b0;
        tick(40);

        // load and halt together in IDLE
        load = 1'b1;
        halt = 1'b1;
        tick(1);
        load = 1'b0;
        halt = 1'b0;
        tick(3);

        repeat (400) begin
            load      = ($urandom_range(7, 0) == 0);
            halt      = ($urandom_range(31, 0) == 0);
            repeat_en = ($urandom_range(3, 0) != 0);
            pattern   = 8'($urandom);
            tick(1);
        end
        load      = 1'b0;
        halt      = 1'b0;
        repeat_en = 1'b0;
        tick(45);

        #1 fin = 1'b1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
